cor_read_seq: RTL and testbench
===============================

// Module: cor_read_seq
// PURPOSE
//  Read-side sequencer for the correlation buffer. Once the write-side address generator reports the
//  buffer full, sweeps a WIN_LEN reference window against every lag of the captured signal.
//  Emits paired read addresses (ref, sig) plus lag/window tags aligned to RAM read latency for the MAC.
//  Sits between the dual-port sample RAM read ports and the correlation accumulator.
// PARAMETERS
//  buf_size      500  samples held in buffer (must match write side)
//  buf_size_MSB  8    MSB of address/lag buses (width = buf_size_MSB+1)
//  win_len       256  reference window length, 1..buf_size
//  rd_latency    2    RAM read latency in clk cycles, 1..4
// PORTS
//  clk         in   1               system clock, rising edge
//  rst_n       in   1               asynchronous reset, active low
//  start_cor   in   1               level; high = correlation session active, low = abort/idle
//  full        in   1               write side has filled the buffer
//  rd_en       out  1               read strobe for both RAM ports
//  ref_address out  buf_size_MSB+1  reference read address = i
//  sig_address out  buf_size_MSB+1  signal read address = lag + i
//  data_valid  out  1               RAM data for (lag,i) present this cycle (rd_en delayed rd_latency)
//  win_first   out  1               with data_valid: i == 0 (accumulator clear)
//  win_last    out  1               with data_valid: i == win_len-1 (accumulator dump)
//  lag_out     out  buf_size_MSB+1  lag tag aligned with data_valid
//  done        out  1               all lags issued and drained; held until start_cor low
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, valid pipeline cleared.
//  NLAG = buf_size - win_len + 1; lag 0..NLAG-1, i 0..win_len-1; lag+i <= buf_size-1 (never wraps).
//  IDLE: -> RUN when start_cor && full (lag=0,i=0). First rd_en the cycle after entering RUN.
//  RUN: rd_en=1 every cycle; i++ ; at i==win_len-1: i=0, lag++ ; after (NLAG-1, win_len-1) -> FLUSH.
//  FLUSH: rd_en=0; wait rd_latency cycles so last data_valid emerges -> DONE.
//  DONE: done=1, rd_en=0; -> IDLE when start_cor low. full dropping in DONE is ignored.
//  Abort: start_cor low in any state -> IDLE next cycle; rd_en=0, valid pipeline flushed same edge
//   (no data_valid after abort edge); counters zeroed. full low in RUN does not abort.
//  Tag pipeline: win_first/win_last/lag_out travel in a rd_latency-deep shift register with rd_en.
//  Total issue cycles = NLAG*win_len (no gap); done rises rd_latency+1 cycles after last rd_en.
//  win_len == buf_size: single lag 0. win_len == 1: win_first and win_last both high every valid.
// CONFIGURATION
//  COR_READ_GAP_EN defined: state GAP inserted after each window (incl. last); rd_en=0 one cycle,
//   giving accumulator a dump slot. Issue cycles = NLAG*(win_len+1).
//  Not defined: back-to-back windows, no GAP state, no bubble in data_valid.
// STRUCTURE
//  Package cor_pkg: FSM state enum (IDLE, RUN, GAP, FLUSH, DONE), NLAG localparam function,
//   shared buf_size/buf_size_MSB defaults used by write and read sides.
//  Sub-module cor_tag_pipe: parameterised rd_latency shift register for {valid,first,last,lag},
//   with synchronous flush input and async rst_n clear.
// TESTING
//  buf_size=8,win_len=4,rd_latency=2: full+start_cor -> 20 rd_en cycles, sig_address 0..3,1..4,...,4..7.
//  Same cfg: data_valid exactly 2 cycles after each rd_en; win_last on i=3 with lag_out 0..4; done 3 cycles after last rd_en.
//  Drop start_cor at 7th read -> rd_en 0 next cycle, no further data_valid, FSM IDLE, done stays 0.
//  win_len=buf_size=8 -> one window lag 0, 8 reads, done; win_len=1 -> first&last every valid.
//  COR_READ_GAP_EN, buf_size=8,win_len=4 -> 1-cycle rd_en gap after each window, 25 issue cycles.
//  Assert rst_n low mid-RUN -> all outputs 0 immediately; start_cor without full -> stays IDLE.

Source files
------------

// File: rtl/cor_pkg.sv
// Shared definitions for the correlation buffer write and read sides.
// Holds the read FSM state encoding and the lag-count helper.
package cor_pkg;

  localparam int buf_size_default     = 500;
  localparam int buf_size_MSB_default = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    GAP,
    FLUSH,
    DONE
  } cor_state_t;

  // Number of lag positions a win_len window can take inside the buffer.
  function automatic int nlag(input int buf_size, input int win_len);
    return buf_size - win_len + 1;
  endfunction

endpackage

// File: rtl/cor_read_seq_if.sv
// Handshake/bus bundle between the correlation read sequencer and its
// environment (session control in, RAM read strobes and MAC tags out).
interface cor_read_seq_if #(parameter int buf_size_MSB = 8);

  logic                  start_cor;
  logic                  full;
  logic                  rd_en;
  logic [buf_size_MSB:0] ref_address;
  logic [buf_size_MSB:0] sig_address;
  logic                  data_valid;
  logic                  win_first;
  logic                  win_last;
  logic [buf_size_MSB:0] lag_out;
  logic                  done;

  modport master (
    input  start_cor, full,
    output rd_en, ref_address, sig_address, data_valid,
           win_first, win_last, lag_out, done
  );

  modport slave (
    output start_cor, full,
    input  rd_en, ref_address, sig_address, data_valid,
           win_first, win_last, lag_out, done
  );

endinterface

// File: rtl/cor_tag_pipe.sv
// Delay line that carries {valid, first, last, lag} alongside the RAM read
// latency so the tags land in the same cycle as the read data.
module cor_tag_pipe #(
  parameter int depth = 2,
  parameter int lag_w = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [lag_w-1:0] in_lag,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic [lag_w-1:0] out_lag
);

  localparam int w = lag_w + 3;

  logic [w-1:0] stage [depth];

  // A synchronous flush drops everything in flight so an aborted session
  // never produces a late data_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < depth; k++) stage[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < depth; k++) stage[k] <= '0;
    end else begin
      stage[0] <= {in_valid, in_first, in_last, in_lag};
      for (int k = 1; k < depth; k++) stage[k] <= stage[k-1];
    end
  end

  assign {out_valid, out_first, out_last, out_lag} = stage[depth-1];

endmodule

// File: rtl/cor_read_seq.sv
// Read-side sequencer: sweeps a win_len reference window over every lag of
// the captured buffer. Optional COR_READ_GAP_EN inserts a one-cycle bubble after each window.
module cor_read_seq
  import cor_pkg::*;
#(
  parameter int buf_size     = 500,
  parameter int buf_size_MSB = 8,
  parameter int win_len      = 256,
  parameter int rd_latency   = 2
) (
  input logic            clk,
  input logic            rst_n,
  cor_read_seq_if.master bus
);

  localparam int aw     = buf_size_MSB + 1;
  localparam int n_lag  = nlag(buf_size, win_len);
  localparam int fw     = (rd_latency > 1) ? $clog2(rd_latency) : 1;

  localparam logic [aw-1:0] last_i     = aw'(win_len - 1);
  localparam logic [aw-1:0] last_lag   = aw'(n_lag - 1);
  localparam logic [fw-1:0] last_flush = fw'(rd_latency - 1);

  cor_state_t    state, state_next;
  logic [aw-1:0] i_cnt, i_next;
  logic [aw-1:0] lag_cnt, lag_next;
  logic [fw-1:0] flush_cnt, flush_next;

  logic          rd_en;
  logic          tag_first;
  logic          tag_last;
  logic [aw-1:0] tag_lag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      i_cnt     <= '0;
      lag_cnt   <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_next;
      i_cnt     <= i_next;
      lag_cnt   <= lag_next;
      flush_cnt <= flush_next;
    end
  end

  always_comb begin
    state_next = state;
    i_next     = i_cnt;
    lag_next   = lag_cnt;
    flush_next = flush_cnt;

    case (state)
      IDLE: begin
        if (bus.start_cor && bus.full) begin
          state_next = RUN;
          i_next     = '0;
          lag_next   = '0;
        end
      end

      RUN: begin
        if (i_cnt == last_i) begin
          i_next = '0;
`ifdef COR_READ_GAP_EN
          state_next = GAP;
`else
          if (lag_cnt == last_lag) begin
            state_next = FLUSH;
            flush_next = '0;
          end else begin
            lag_next = lag_cnt + 1'b1;
          end
`endif
        end else begin
          i_next = i_cnt + 1'b1;
        end
      end

      // The bubble follows every window, including the last, so the lag
      // decision is deferred to here.
      GAP: begin
        if (lag_cnt == last_lag) begin
          state_next = FLUSH;
          flush_next = '0;
        end else begin
          state_next = RUN;
          lag_next   = lag_cnt + 1'b1;
        end
      end

      FLUSH: begin
        if (flush_cnt == last_flush) begin
          state_next = DONE;
        end else begin
          flush_next = flush_cnt + 1'b1;
        end
      end

      DONE: state_next = DONE;

      default: state_next = IDLE;
    endcase

    // Dropping start_cor aborts from any state and wins over everything above.
    if (!bus.start_cor) begin
      state_next = IDLE;
      i_next     = '0;
      lag_next   = '0;
      flush_next = '0;
    end
  end

  assign rd_en     = (state == RUN);
  assign tag_first = rd_en && (i_cnt == '0);
  assign tag_last  = rd_en && (i_cnt == last_i);
  assign tag_lag   = rd_en ? lag_cnt : '0;

  cor_tag_pipe #(
    .depth (rd_latency),
    .lag_w (aw)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!bus.start_cor),
    .in_valid  (rd_en),
    .in_first  (tag_first),
    .in_last   (tag_last),
    .in_lag    (tag_lag),
    .out_valid (bus.data_valid),
    .out_first (bus.win_first),
    .out_last  (bus.win_last),
    .out_lag   (bus.lag_out)
  );

  assign bus.rd_en       = rd_en;
  assign bus.ref_address = i_cnt;
  assign bus.sig_address = lag_cnt + i_cnt;
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_cor_read_seq.sv
// Scoreboard bench for cor_read_seq: three instances (win_len 4, 8, 1) on an
// 8-sample buffer; expectations queued by stimulus, popped by the monitor.
module tb_cor_read_seq;

  localparam int BS   = 8;
  localparam int MSB  = 3;
  localparam int AW   = MSB + 1;
  localparam int LAT  = 2;
  localparam int NDUT = 3;
`ifdef COR_READ_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int DONE_LAT = LAT + 1 + GAP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic          start_cor [NDUT];
  logic          full      [NDUT];
  logic          rd_en     [NDUT];
  logic          dv        [NDUT];
  logic          wf        [NDUT];
  logic          wl        [NDUT];
  logic          done      [NDUT];
  logic [AW-1:0] ref_a     [NDUT];
  logic [AW-1:0] sig_a     [NDUT];
  logic [AW-1:0] lag_o     [NDUT];

  int checks = 0;
  int fails  = 0;
  int cycle  = 0;
  int issue_cnt [NDUT];
  int first_rd  [NDUT];
  int last_rd   [NDUT];
  logic done_q  [NDUT];

  logic [2*AW-1:0] exp_addr_q [NDUT][$];
  logic [AW+1:0]   exp_tag_q  [NDUT][$];
  int              rd_ts_q    [NDUT][$];

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    localparam int WL = (g == 0) ? 4 : ((g == 1) ? 8 : 1);
    cor_read_seq_if #(.buf_size_MSB(MSB)) bus ();
    assign bus.start_cor = start_cor[g];
    assign bus.full      = full[g];
    assign rd_en[g]      = bus.rd_en;
    assign dv[g]         = bus.data_valid;
    assign wf[g]         = bus.win_first;
    assign wl[g]         = bus.win_last;
    assign done[g]       = bus.done;
    assign ref_a[g]      = bus.ref_address;
    assign sig_a[g]      = bus.sig_address;
    assign lag_o[g]      = bus.lag_out;

    cor_read_seq #(
      .buf_size     (BS),
      .buf_size_MSB (MSB),
      .win_len      (WL),
      .rd_latency   (LAT)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected addresses on every rd_en and expected tags on
  // every data_valid; also times data_valid and done against the reads.
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (rd_en[g] === 1'b1) begin
        if (issue_cnt[g] == 0) first_rd[g] = cycle;
        issue_cnt[g]++;
        last_rd[g] = cycle;
        rd_ts_q[g].push_back(cycle);
        if (exp_addr_q[g].size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected_rd_en", g), 1, 0);
        end else begin
          logic [2*AW-1:0] ea;
          ea = exp_addr_q[g].pop_front();
          checkOutput($sformatf("dut%0d ref_address", g), 32'(ref_a[g]), 32'(ea[2*AW-1:AW]));
          checkOutput($sformatf("dut%0d sig_address", g), 32'(sig_a[g]), 32'(ea[AW-1:0]));
        end
      end
      if (dv[g] === 1'b1) begin
        if (exp_tag_q[g].size() == 0) begin
          checkOutput($sformatf("dut%0d unexpected_data_valid", g), 1, 0);
        end else begin
          logic [AW+1:0] et;
          et = exp_tag_q[g].pop_front();
          checkOutput($sformatf("dut%0d win_first", g), 32'(wf[g]), 32'(et[AW+1]));
          checkOutput($sformatf("dut%0d win_last", g), 32'(wl[g]), 32'(et[AW]));
          checkOutput($sformatf("dut%0d lag_out", g), 32'(lag_o[g]), 32'(et[AW-1:0]));
        end
        if (rd_ts_q[g].size() != 0)
          checkOutput($sformatf("dut%0d valid_latency", g), cycle - rd_ts_q[g].pop_front(), LAT);
      end
      if (done[g] === 1'b1 && done_q[g] !== 1'b1)
        checkOutput($sformatf("dut%0d done_latency", g), cycle - last_rd[g], DONE_LAT);
      done_q[g] = done[g];
    end
  end

  // Full session on one instance: queue the whole sweep, run to done, then
  // confirm done holds through a full drop and clears on start_cor low.
  task automatic applyStimulus(input int g, input int win);
    int n_lag;
    int t;
    n_lag = BS - win + 1;
    for (int lag = 0; lag < n_lag; lag++) begin
      for (int i = 0; i < win; i++) begin
        exp_addr_q[g].push_back({AW'(i), AW'(lag + i)});
        exp_tag_q[g].push_back({(i == 0), (i == win - 1), AW'(lag)});
      end
    end
    @(negedge clk);
    issue_cnt[g] = 0;
    full[g] = 1'b1;
    start_cor[g] = 1'b1;
    t = 0;
    while (done[g] !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput($sformatf("dut%0d done_reached", g), (t < 300), 1);
    checkOutput($sformatf("dut%0d rd_count", g), issue_cnt[g], n_lag * win);
    checkOutput($sformatf("dut%0d issue_span", g), last_rd[g] - first_rd[g] + 1, n_lag * (win + GAP) - GAP);
    full[g] = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput($sformatf("dut%0d done_held", g), 32'(done[g]), 1);
    start_cor[g] = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("dut%0d done_cleared", g), 32'(done[g]), 0);
    checkOutput($sformatf("dut%0d addr_q_drained", g), exp_addr_q[g].size(), 0);
    checkOutput($sformatf("dut%0d tag_q_drained", g), exp_tag_q[g].size(), 0);
  endtask

  // Abort on the 7th read: reads 1..5 have surfaced by the abort edge,
  // reads 6 and 7 must be flushed.
  task automatic applyAbort();
    int t;
    for (int k = 0; k < 7; k++) begin
      exp_addr_q[0].push_back({AW'(k % 4), AW'(k / 4 + k % 4)});
      if (k < 5) exp_tag_q[0].push_back({(k % 4 == 0), (k % 4 == 3), AW'(k / 4)});
    end
    @(negedge clk);
    issue_cnt[0] = 0;
    full[0] = 1'b1;
    start_cor[0] = 1'b1;
    t = 0;
    while (issue_cnt[0] < 7 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    checkOutput("abort seventh_read_seen", issue_cnt[0], 7);
    start_cor[0] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      checkOutput("abort rd_en_low", 32'(rd_en[0]), 0);
      checkOutput("abort data_valid_low", 32'(dv[0]), 0);
      checkOutput("abort done_low", 32'(done[0]), 0);
    end
    checkOutput("abort tag_q_drained", exp_tag_q[0].size(), 0);
    checkOutput("abort addr_q_drained", exp_addr_q[0].size(), 0);
    rd_ts_q[0].delete();
    full[0] = 1'b0;
  endtask

  task automatic applyResetMidRun();
    int t;
    for (int lag = 0; lag < 5; lag++) begin
      for (int i = 0; i < 4; i++) begin
        exp_addr_q[0].push_back({AW'(i), AW'(lag + i)});
        exp_tag_q[0].push_back({(i == 0), (i == 3), AW'(lag)});
      end
    end
    @(negedge clk);
    issue_cnt[0] = 0;
    full[0] = 1'b1;
    start_cor[0] = 1'b1;
    t = 0;
    while (issue_cnt[0] < 9 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    checkOutput("reset_mid_run reached_run", issue_cnt[0], 9);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_run rd_en", 32'(rd_en[0]), 0);
    checkOutput("reset_mid_run data_valid", 32'(dv[0]), 0);
    checkOutput("reset_mid_run win_first", 32'(wf[0]), 0);
    checkOutput("reset_mid_run win_last", 32'(wl[0]), 0);
    checkOutput("reset_mid_run lag_out", 32'(lag_o[0]), 0);
    checkOutput("reset_mid_run ref_address", 32'(ref_a[0]), 0);
    checkOutput("reset_mid_run sig_address", 32'(sig_a[0]), 0);
    checkOutput("reset_mid_run done", 32'(done[0]), 0);
    start_cor[0] = 1'b0;
    full[0] = 1'b0;
    @(negedge clk);
    exp_addr_q[0].delete();
    exp_tag_q[0].delete();
    rd_ts_q[0].delete();
    rst_n = 1'b1;
  endtask

  task automatic applyStartWithoutFull();
    @(negedge clk);
    issue_cnt[0] = 0;
    start_cor[0] = 1'b1;
    full[0] = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("no_full rd_count", issue_cnt[0], 0);
    checkOutput("no_full done", 32'(done[0]), 0);
    start_cor[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      start_cor[g] = 1'b0;
      full[g]      = 1'b0;
      issue_cnt[g] = 0;
      first_rd[g]  = 0;
      last_rd[g]   = 0;
      done_q[g]    = 1'b0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("dut%0d reset rd_en", g), 32'(rd_en[g]), 0);
      checkOutput($sformatf("dut%0d reset data_valid", g), 32'(dv[g]), 0);
      checkOutput($sformatf("dut%0d reset done", g), 32'(done[g]), 0);
      checkOutput($sformatf("dut%0d reset sig_address", g), 32'(sig_a[g]), 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(0, 4);
    applyStimulus(1, 8);
    applyStimulus(2, 1);
    applyAbort();
    applyStimulus(0, 4);
    applyResetMidRun();
    applyStartWithoutFull();
    applyStimulus(0, 4);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
